// File: rtl/led_matrix_scanner.sv
// Scans an 8x8 red/green matrix one row per DIV-cycle slot from a shadow frame latched at frame start.
// Latency: Moore outputs from registered state; no backpressure, enable is sampled only at frame boundaries.
module led_matrix_scanner #(
    parameter int unsigned DIV   = 1024,
    parameter int unsigned BLANK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0][7:0] red_array,
    input  logic [7:0][7:0] green_array,
    output logic [7:0]      row_n,
    output logic [7:0]      red_drv,
    output logic [7:0]      green_drv,
    output logic [2:0]      cur_row,
    output logic            frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
    localparam logic [15:0] BLANK_M1 = 16'(BLANK - 1);
    localparam logic [15:0] BLANK_C  = 16'(BLANK);

    state_t          state, state_nxt;
    logic [2:0]      row, row_nxt;
    logic [15:0]     cnt, cnt_nxt;
    logic            capture;
    logic            slot_end;
    logic [7:0][7:0] shadow_red, shadow_green;

    assign slot_end = (cnt == DIV_M1);

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        cnt_nxt   = cnt + 16'd1;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = cnt;
                if (enable) begin
                    state_nxt = S_BLANK;
                    row_nxt   = 3'd0;
                    cnt_nxt   = 16'd0;
                    capture   = 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt == BLANK_M1) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = BLANK_C;
                end
            end
            S_DRIVE: begin
                if (slot_end) begin
                    cnt_nxt = 16'd0;
                    if (row != 3'd7) begin
                        state_nxt = S_BLANK;
                        row_nxt   = row + 3'd1;
                    end else if (enable) begin
                        // Back-to-back frame: skip IDLE so the frame period stays 8*DIV.
                        state_nxt = S_BLANK;
                        row_nxt   = 3'd0;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        row_nxt   = 3'd0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                row_nxt   = 3'd0;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            row          <= 3'd0;
            cnt          <= 16'd0;
            shadow_red   <= '0;
            shadow_green <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                shadow_red   <= red_array;
                shadow_green <= green_array;
            end
        end
    end

    // Decoded purely from registers, so an asynchronous reset blanks the panel at once.
    always_comb begin
        row_n      = 8'hFF;
        red_drv    = 8'h00;
        green_drv  = 8'h00;
        cur_row    = 3'd0;
        frame_done = 1'b0;
        if (state == S_DRIVE) begin
            row_n      = ~(8'd1 << row);
            red_drv    = shadow_red[row];
            green_drv  = shadow_green[row];
            frame_done = slot_end && (row == 3'd7);
        end
        if (state != S_IDLE) begin
            cur_row = row;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DIV=8, BLANK=2 (64-cycle frames).
module tb_led_matrix_scanner;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [7:0][7:0] red_array, green_array;
    logic [7:0]      row_n, red_drv, green_drv;
    logic [2:0]      cur_row;
    logic            frame_done;

    led_matrix_scanner #(.DIV(8), .BLANK(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .red_array   (red_array),
        .green_array (green_array),
        .row_n       (row_n),
        .red_drv     (red_drv),
        .green_drv   (green_drv),
        .cur_row     (cur_row),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int k;

    typedef struct {
        int         k;
        logic [7:0] rn;
        logic [7:0] rd;
        logic [7:0] gd;
        logic [2:0] cr;
        logic       fd;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rn, input logic [7:0] rd,
                           input logic [7:0] gd, input logic [2:0] cr, input logic fd);
        chk({tag, " row_n"}, 32'(row_n), 32'(rn));
        chk({tag, " red_drv"}, 32'(red_drv), 32'(rd));
        chk({tag, " green_drv"}, 32'(green_drv), 32'(gd));
        chk({tag, " cur_row"}, 32'(cur_row), 32'(cr));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int t);
        while (k < t) tick();
    endtask

    initial begin
        int bad, pulses;

        vt[0]  = '{0,  8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        vt[1]  = '{1,  8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        vt[2]  = '{2,  8'hFE, 8'h81, 8'h00, 3'd0, 1'b0};
        vt[3]  = '{7,  8'hFE, 8'h81, 8'h00, 3'd0, 1'b0};
        vt[4]  = '{8,  8'hFF, 8'h00, 8'h00, 3'd1, 1'b0};
        vt[5]  = '{10, 8'hFD, 8'h00, 8'h00, 3'd1, 1'b0};
        vt[6]  = '{24, 8'hFF, 8'h00, 8'h00, 3'd3, 1'b0};
        vt[7]  = '{25, 8'hFF, 8'h00, 8'h00, 3'd3, 1'b0};
        vt[8]  = '{26, 8'hF7, 8'h00, 8'h18, 3'd3, 1'b0};
        vt[9]  = '{31, 8'hF7, 8'h00, 8'h18, 3'd3, 1'b0};
        vt[10] = '{63, 8'h7F, 8'h00, 8'h00, 3'd7, 1'b1};
        vt[11] = '{64, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        vt[12] = '{66, 8'hFE, 8'h81, 8'h00, 3'd0, 1'b0};

        // Held in reset with live arrays and enable: outputs stay blank.
        k = 0;
        reset  = 1'b0;
        enable = 1'b1;
        for (int r = 0; r < 8; r++) begin
            red_array[r]   = 8'($urandom);
            green_array[r] = 8'($urandom);
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("rst%0d", i), 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0);
        end

        red_array      = '0;
        green_array    = '0;
        red_array[0]   = 8'h81;
        green_array[3] = 8'h18;
        reset = 1'b1;
        k = -1;
        tick();  // IDLE -> BLANK capture edge, frame cycle 0

        for (int i = 0; i < 13; i++) begin
            goto(vt[i].k);
            chk_all($sformatf("vec%0d", i), vt[i].rn, vt[i].rd, vt[i].gd, vt[i].cr, vt[i].fd);
        end

        // Array change mid-frame shows up only from the next capture.
        goto(83);
        red_array[5] = 8'hFF;
        goto(106);
        chk("notear row_n", 32'(row_n), 32'hDF);
        chk("notear red", 32'(red_drv), 32'h00);
        goto(170);
        chk("nextframe row_n", 32'(row_n), 32'hDF);
        chk("nextframe red", 32'(red_drv), 32'hFF);

        // frame_done cadence over 200 cycles.
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (frame_done !== ((k % 64) == 63)) bad++;
            if (frame_done === 1'b1) begin
                pulses++;
                if (cur_row !== 3'd7 || row_n !== 8'h7F) bad++;
            end
        end
        chk("fd cadence errors", 32'(bad), 32'd0);
        chk("fd pulse count", 32'(pulses), 32'd3);

        // Dropping enable in row 4 still completes the frame, then idles.
        goto(384 + 32 + 3);
        enable = 1'b0;
        goto(384 + 40 + 2);
        chk_all("drop row5", 8'hDF, 8'hFF, 8'h00, 3'd5, 1'b0);
        goto(384 + 56 + 2);
        chk_all("drop row7", 8'h7F, 8'h00, 8'h00, 3'd7, 1'b0);
        goto(447);
        chk("drop fd", 32'(frame_done), 32'd1);
        tick();
        chk_all("drop idle", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (row_n !== 8'hFF || frame_done !== 1'b0) bad++;
        end
        chk("idle stays blank", 32'(bad), 32'd0);

        // Async reset during row 6 drive, then restart through IDLE.
        red_array      = '0;
        green_array    = '0;
        red_array[6]   = 8'h3C;
        green_array[6] = 8'hC3;
        enable = 1'b1;
        k = -1;
        tick();
        goto(52);
        chk_all("r6 drive", 8'hBF, 8'h3C, 8'hC3, 3'd6, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async rst", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0);
        red_array      = '0;
        green_array    = '0;
        red_array[0]   = 8'h0F;
        green_array[0] = 8'hF0;
        tick();
        chk_all("in rst", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0);
        reset = 1'b1;
        k = -1;
        tick();
        red_array[0]   = 8'hFF;
        green_array[0] = 8'hFF;
        chk_all("restart blank", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0);
        goto(2);
        chk_all("restart row0", 8'hFE, 8'h0F, 8'hF0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
